// File: rtl/chaos_stream_ctrl.sv
// chaos_stream_ctrl
//   Sequences one image-encryption pass. The controller kicks the chaotic PRNG and drops its
//   warm-up samples. It then joins the pixel stream with the keystream, using one key byte per
//   pixel, and emits XOR-ciphered pixels through a single full-throughput output register.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   start_i          begin a frame (sampled only while idle)
//   num_pixels_i     frame length, latched on an accepted start
//   abort_i          synchronous cancel of the current frame (priority over everything)
//   busy_o           high whenever a frame is in progress
//   done_o           one-cycle pulse in the cycle idle is re-entered after a completed frame
//   prng_kick_o      one-cycle pulse that starts the PRNG
//   prng_valid_i     PRNG sample available
//   prng_data_i      PRNG sample (only the low BIT_WIDTH bits are used)
//   prng_ready_o     sample consumed when valid && ready
//   pix_in_valid_i   plaintext pixel available
//   pix_in_data_i    plaintext pixel
//   pix_in_ready_o   pixel consumed when valid && ready
//   pix_out_valid_o  ciphered pixel valid
//   pix_out_data_o   pixel ^ key byte
//   pix_out_last_o   final pixel of the frame
//   pix_out_ready_i  sink accepts when valid && ready
module chaos_stream_ctrl #(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned WARMUP    = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_pixels_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 prng_kick_o,
  input  logic                 prng_valid_i,
  input  logic [PRECISION-1:0] prng_data_i,
  output logic                 prng_ready_o,
  input  logic                 pix_in_valid_i,
  input  logic [BIT_WIDTH-1:0] pix_in_data_i,
  output logic                 pix_in_ready_o,
  output logic                 pix_out_valid_o,
  output logic [BIT_WIDTH-1:0] pix_out_data_o,
  output logic                 pix_out_last_o,
  input  logic                 pix_out_ready_i
);

  // Wide enough to hold WARMUP itself.
  localparam int unsigned WarmW = $clog2(WARMUP + 1);

  typedef enum logic [2:0] {
    StIdle,
    StKick,
    StWarm,
    StRun,
    StDrain
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [WarmW-1:0]     warm_cnt_q, warm_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;

  logic fire;
  logic out_take;
  logic last_fire;
  logic warm_last;

  // Upper PRNG bits carry no key material for this pixel width.
  logic unused_prng_hi;
  if (PRECISION > BIT_WIDTH) begin : g_unused_hi
    assign unused_prng_hi = ^prng_data_i[PRECISION-1:BIT_WIDTH];
  end else begin : g_no_unused_hi
    assign unused_prng_hi = 1'b0;
  end

  // Join: a pixel and a key byte are taken together, and only when the output register is free
  // or is being emptied in the same cycle (this keeps 1 pixel/clk with no bubble).
  assign out_take  = out_valid_q && pix_out_ready_i;
  assign fire      = (state_q == StRun) && !abort_i && prng_valid_i && pix_in_valid_i &&
                     (!out_valid_q || pix_out_ready_i);
  assign last_fire = fire && (remaining_q == CNT_W'(1));
  assign warm_last = prng_valid_i && (warm_cnt_q == WarmW'(WARMUP - 1));

  // ---------------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && (num_pixels_i != '0)) begin
            state_d = StKick;
          end
        end
        StKick: state_d = StWarm;
        StWarm: begin
          if (warm_last) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (last_fire) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (out_take) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath / counter next-state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    remaining_d = remaining_q;
    warm_cnt_d  = warm_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (abort_i && (state_q != StIdle)) begin
      // In-flight output is dropped; no done for a cancelled frame.
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (num_pixels_i != '0) begin
              remaining_d = num_pixels_i;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StKick: warm_cnt_d = '0;
        StWarm: begin
          if (prng_valid_i) begin
            warm_cnt_d = warm_cnt_q + WarmW'(1);
          end
        end
        StRun: begin
          if (out_take) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
          if (fire) begin
            out_data_d  = pix_in_data_i ^ prng_data_i[BIT_WIDTH-1:0];
            out_valid_d = 1'b1;
            out_last_d  = last_fire;
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
        StDrain: begin
          if (out_take) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      remaining_q <= '0;
      warm_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      warm_cnt_q  <= warm_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    busy_o         = 1'b1;
    prng_kick_o    = 1'b0;
    prng_ready_o   = 1'b0;
    pix_in_ready_o = 1'b0;
    unique case (state_q)
      StIdle:  busy_o = 1'b0;
      StKick:  prng_kick_o = 1'b1;
      StWarm:  prng_ready_o = !abort_i;
      StRun: begin
        prng_ready_o   = fire;
        pix_in_ready_o = fire;
      end
      StDrain: busy_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  assign done_o          = done_q;
  assign pix_out_valid_o = out_valid_q;
  assign pix_out_data_o  = out_data_q;
  assign pix_out_last_o  = out_last_q;

endmodule

// File: tb/tb_chaos_stream_ctrl.sv
// Self-checking bench for chaos_stream_ctrl. Frames are described by a table of records; the
// expected ciphertext comes from a simple model: the k-th pixel of a frame is XORed with the low
// byte of the (WARMUP+k)-th PRNG sample handed over after the kick.
module tb_chaos_stream_ctrl;

  localparam int WARMUP = 16;
  localparam int CNT_W  = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_pixels;
  logic             abort;
  logic             busy, done, prng_kick;
  logic             prng_valid;
  logic [31:0]      prng_data;
  logic             prng_ready;
  logic             pix_in_valid;
  logic [7:0]       pix_in_data;
  logic             pix_in_ready;
  logic             pix_out_valid;
  logic [7:0]       pix_out_data;
  logic             pix_out_last;
  logic             pix_out_ready;

  int n_total = 0;
  int n_pass  = 0;

  chaos_stream_ctrl #(
    .PRECISION(32),
    .BIT_WIDTH(8),
    .CNT_W    (CNT_W),
    .WARMUP   (WARMUP)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .num_pixels_i   (num_pixels),
    .abort_i        (abort),
    .busy_o         (busy),
    .done_o         (done),
    .prng_kick_o    (prng_kick),
    .prng_valid_i   (prng_valid),
    .prng_data_i    (prng_data),
    .prng_ready_o   (prng_ready),
    .pix_in_valid_i (pix_in_valid),
    .pix_in_data_i  (pix_in_data),
    .pix_in_ready_o (pix_in_ready),
    .pix_out_valid_o(pix_out_valid),
    .pix_out_data_o (pix_out_data),
    .pix_out_last_o (pix_out_last),
    .pix_out_ready_i(pix_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;          // frame length
    int pv_pct;     // PRNG valid probability (%)
    int iv_pct;     // pixel valid probability (%)
    int or_pct;     // sink ready probability (%)
    bit or_toggle;  // sink ready toggles every 2 clk instead
    int gap_at;     // pixel index before which pix_in_valid drops for 5 clk (-1: none)
    int kind;       // 0 none, 1 abort after abort_at warm samples, 2 abort / 3 reset after
                    // abort_at outputs
    int abort_at;
    bit restart;    // pulse start again after the first output
    int exp_kicks;
    int exp_outs;
    int exp_done;
  } vec_t;

  function automatic vec_t mk(input int n, input int pv, input int iv, input int orr,
                              input bit tog, input int gap, input int kind, input int at,
                              input bit rs, input int ek, input int eo, input int ed);
    vec_t v;
    v.n = n; v.pv_pct = pv; v.iv_pct = iv; v.or_pct = orr; v.or_toggle = tog; v.gap_at = gap;
    v.kind = kind; v.abort_at = at; v.restart = rs;
    v.exp_kicks = ek; v.exp_outs = eo; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; num_pixels = '0;
    prng_valid = 1'b0; prng_data = '0; pix_in_valid = 1'b0; pix_in_data = '0;
    pix_out_ready = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] smp[$];
    logic [7:0]  pix[$];
    logic [7:0]  exp_d;
    logic [7:0]  hold_data;
    logic        hold_last;
    int p_idx = 0, x_idx = 0, outs = 0, kicks = 0, dones = 0, gap_left = 0, tail = -1;
    bit gap_used = 0, in_gap = 0, hold_valid = 0, aborting = 0, post_abort = 0;
    bit fired = 0, restarted = 0, ended = 0, trig, prng_hs, pin_hs, out_hs;
    bit exp_done_cur = 0, exp_done_nx = 0;

    for (int i = 0; i < v.n + WARMUP + 4; i++) smp.push_back($urandom);
    for (int i = 0; i < v.n; i++) pix.push_back(8'($urandom));

    @(posedge clk); #1;
    idle_inputs();
    start = 1'b1;
    num_pixels = CNT_W'(v.n);
    if (v.n == 0) exp_done_nx = 1;

    for (int c = 0; c < 4000 && !ended; c++) begin
      @(negedge clk);
      chk("done_timing", done, exp_done_cur);
      if (v.n == 0) begin
        chk("zero_busy", busy, 0);
        chk("zero_kick", prng_kick, 0);
      end
      if (done) dones++;
      if (prng_kick) kicks++;
      if (p_idx >= WARMUP) chk("join_ready", prng_ready, pix_in_ready);
      else chk("warm_no_pixel", pix_in_ready, 0);
      if (in_gap) chk("gap_no_key", prng_ready, 0);
      if (hold_valid) begin
        chk("stall_valid", pix_out_valid, 1);
        chk("stall_data", pix_out_data, hold_data);
        chk("stall_last", pix_out_last, hold_last);
      end
      if (aborting) begin
        chk("abort_no_prng", prng_ready, 0);
        chk("abort_no_pix", pix_in_ready, 0);
      end
      if (post_abort) begin
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_out_valid, 0);
        post_abort = 0;
        tail = 3;
      end
      prng_hs = prng_valid && prng_ready;
      pin_hs  = pix_in_valid && pix_in_ready;
      out_hs  = pix_out_valid && pix_out_ready;
      if (out_hs) begin
        if (outs < v.n) begin
          exp_d = pix[outs] ^ smp[WARMUP + outs][7:0];
          chk("out_data", pix_out_data, exp_d);
          chk("out_last", pix_out_last, (outs == v.n - 1));
        end else begin
          chk("extra_output", outs, v.n - 1);
        end
        outs++;
        if (outs == v.n) exp_done_nx = 1;
      end
      hold_valid = pix_out_valid && !pix_out_ready;
      hold_data  = pix_out_data;
      hold_last  = pix_out_last;
      if (done && tail < 0) tail = 3;
      if (aborting) begin
        aborting = 0; post_abort = 1; hold_valid = 0;
      end

      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (prng_hs) p_idx++;
      if (pin_hs) x_idx++;
      exp_done_cur = exp_done_nx;
      exp_done_nx  = 0;
      if (tail == 0) ended = 1;
      else if (tail > 0) tail--;

      trig = 0;
      if (!fired) begin
        if (v.kind == 1) trig = (p_idx == v.abort_at);
        else if (v.kind >= 2) trig = (outs == v.abort_at);
      end
      if (trig && v.kind == 3) begin
        fired = 1;
        reset = 1'b1;
        #1;
        chk("async_reset_outs",
            {busy, done, prng_kick, prng_ready, pix_in_ready, pix_out_valid, pix_out_last,
             pix_out_data}, 0);
        #1 reset = 1'b0;
        hold_valid = 0;
        tail = 3;
      end else if (trig) begin
        fired = 1;
        abort = 1'b1;
        aborting = 1;
      end
      if (v.restart && !restarted && outs == 1) begin
        start = 1'b1;
        num_pixels = CNT_W'(7);
        restarted = 1;
      end

      in_gap = 0;
      if (fired || ended || tail >= 0) begin
        prng_valid = 1'b0;
        pix_in_valid = 1'b0;
      end else begin
        prng_valid = (p_idx < smp.size()) && ($urandom_range(99) < v.pv_pct);
        prng_data  = (p_idx < smp.size()) ? smp[p_idx] : 32'h0;
        if (v.gap_at >= 0 && !gap_used && x_idx == v.gap_at && p_idx >= WARMUP) begin
          gap_used = 1;
          gap_left = 5;
        end
        if (gap_left > 0) begin
          pix_in_valid = 1'b0;
          in_gap = 1;
          gap_left--;
        end else begin
          pix_in_valid = (x_idx < v.n) && ($urandom_range(99) < v.iv_pct);
        end
        pix_in_data = (x_idx < v.n) ? pix[x_idx] : 8'h00;
      end
      if (v.or_toggle) pix_out_ready = ((c / 2) % 2 == 0);
      else pix_out_ready = ($urandom_range(99) < v.or_pct);
      if (aborting) pix_out_ready = 1'b0;
    end

    chk("frame_terminated", ended, 1);
    chk("kick_count", kicks, v.exp_kicks);
    chk("output_count", outs, v.exp_outs);
    chk("done_count", dones, v.exp_done);
    chk("idle_after_frame", busy, 0);
    idle_inputs();
  endtask

  vec_t tbl[11];

  initial begin
    idle_inputs();
    reset = 1'b1;

    tbl[0]  = mk(4, 100, 100, 100, 0, -1, 0, 0, 0, 1, 4, 1);  // basic frame
    tbl[1]  = mk(4, 100, 100, 100, 1, -1, 0, 0, 0, 1, 4, 1);  // sink toggles every 2 clk
    tbl[2]  = mk(6, 100, 100, 100, 0,  2, 0, 0, 0, 1, 6, 1);  // pixel gap, PRNG stays valid
    tbl[3]  = mk(0, 100, 100, 100, 0, -1, 0, 0, 0, 0, 0, 1);  // zero-length frame
    tbl[4]  = mk(3, 100, 100, 100, 0, -1, 1, 5, 0, 1, 0, 0);  // abort in WARM
    tbl[5]  = mk(1, 100, 100, 100, 0, -1, 0, 0, 0, 1, 1, 1);
    tbl[6]  = mk(4, 100, 100, 100, 0, -1, 2, 2, 0, 1, 2, 0);  // abort after 2 outputs
    tbl[7]  = mk(1, 100, 100, 100, 0, -1, 0, 0, 0, 1, 1, 1);
    tbl[8]  = mk(4, 100, 100, 100, 0, -1, 0, 0, 1, 1, 4, 1);  // start again during RUN
    tbl[9]  = mk(4, 100, 100, 100, 0, -1, 3, 2, 0, 1, 2, 0);  // reset mid-RUN
    tbl[10] = mk(1,  60,  60,  60, 0, -1, 0, 0, 0, 1, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {busy, done, prng_kick, prng_ready, pix_in_ready, pix_out_valid, pix_out_last,
         pix_out_data}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Hand sequence: abort while idle is ignored, then a zero-length start.
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_done", done, 0);
    chk("idle_abort_busy2", busy, 0);
    @(posedge clk); #1 start = 1'b1; num_pixels = '0;
    @(negedge clk);
    chk("zero_start_done_early", done, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero_start_done", done, 1);
    chk("zero_start_busy", busy, 0);
    chk("zero_start_kick", prng_kick, 0);
    @(posedge clk);
    @(negedge clk);
    chk("zero_start_done_once", done, 0);

    for (int i = 0; i < 11; i++) run_frame(tbl[i]);

    for (int i = 0; i < 10; i++) begin
      int n;
      n = int'($urandom_range(12, 1));
      run_frame(mk(n, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                   int'($urandom_range(100, 30)), bit'($urandom_range(1)),
                   ($urandom_range(1) == 1) ? int'($urandom_range(n - 1)) : -1,
                   0, 0, 0, 1, n, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
